// File: rtl/game_pkg.sv
// Shared encodings and scoring constants for the Pac-Man game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAY        = 3'd1,
    POWER       = 3'd2,
    DYING       = 3'd3,
    LEVEL_CLEAR = 3'd4,
    GAME_OVER   = 3'd5
  } state_t;

  localparam int PELLET_PTS       = 10;
  localparam int POWER_PTS        = 50;
  localparam int GHOST_PTS_BASE   = 200;
  localparam int GHOST_PTS_MAX    = 1600;
  localparam int EXTRA_LIFE_SCORE = 10000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-granular down-counter; done pulses on the frame where the count runs out.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q, active_d;

  // A loaded value of 0 or 1 both expire on the next tick.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (load) begin
      cnt_d    = load_val;
      active_d = 1'b1;
    end else if (tick && active_q) begin
      if (cnt_q <= W'(1)) begin
        done     = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/game_state_sequencer.sv
// Frame-level Pac-Man game sequencer: state, score, lives, level, frightened timer.
// Optional build macro EXTRA_LIFE_EN adds a one-time bonus life at 10000 points.
//   state       | meaning
//   IDLE        | attract screen, waiting for start_key
//   PLAY        | normal play, hits scored
//   POWER       | ghosts frightened, eaten ghosts score a doubling bonus
//   DYING       | death freeze, then resume or game over
//   LEVEL_CLEAR | all pellets eaten, pause before next level
//   GAME_OVER   | score held until start_key
module game_state_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int PELLET_COUNT = 64,
  parameter int POWER_FRAMES = 180,
  parameter int DEATH_FRAMES = 60,
  parameter int CLEAR_FRAMES = 90,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_key,
  input  logic               hit_pellet,
  input  logic               hit_power,
  input  logic               hit_ghost,
  output logic [2:0]         game_state,
  output logic               freeze_motion,
  output logic               ghost_frightened,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [3:0]         level,
  output logic               event_pulse
);

  localparam int PW = $clog2(PELLET_COUNT + 1);
  localparam int TW = $clog2(max3(POWER_FRAMES, DEATH_FRAMES, CLEAR_FRAMES) + 1);
  localparam int MW = $clog2(GHOST_PTS_MAX + 1);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [3:0]         level_q, level_d;
  logic [PW-1:0]      pellets_q, pellets_d;
  logic [MW-1:0]      mult_q, mult_d;
  logic               freeze_q, freeze_d;
  logic               fright_q, fright_d;
  logic               event_q, event_d;
`ifdef EXTRA_LIFE_EN
  logic               bonus_q, bonus_d;
`endif

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_done;

  logic [1:0]         pel_hits;
  logic [PW-1:0]      pel_left;
  logic [MW:0]        add;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_sat;
  logic [MW-1:0]      mult_next;

  frame_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (startOfFrame),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign pel_hits  = {1'b0, hit_pellet} + {1'b0, hit_power};
  assign pel_left  = (pellets_q > PW'(pel_hits)) ? pellets_q - PW'(pel_hits) : '0;
  assign add       = (hit_pellet ? (MW+1)'(PELLET_PTS) : '0)
                   + (hit_power  ? (MW+1)'(POWER_PTS)  : '0)
                   + ((state_q == POWER && hit_ghost) ? {1'b0, mult_q} : '0);
  assign sum       = {1'b0, score_q} + (SCORE_W+1)'(add);
  assign score_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  assign mult_next = (mult_q >= MW'(GHOST_PTS_MAX / 2)) ? MW'(GHOST_PTS_MAX)
                                                        : {mult_q[MW-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    level_d   = level_q;
    pellets_d = pellets_q;
    mult_d    = mult_q;
    event_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
`ifdef EXTRA_LIFE_EN
    bonus_d   = bonus_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_key) begin
          state_d   = PLAY;
          score_d   = '0;
          lives_d   = 3'(LIVES_INIT);
          level_d   = 4'd1;
          pellets_d = PW'(PELLET_COUNT);
          mult_d    = MW'(GHOST_PTS_BASE);
`ifdef EXTRA_LIFE_EN
          bonus_d   = 1'b0;
`endif
        end
      end
      PLAY, POWER: begin
        if (state_q == PLAY && hit_ghost) begin
          // Touching a ghost outside POWER discards any pellet eaten that cycle.
          lives_d  = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          state_d  = DYING;
          tmr_load = 1'b1;
          tmr_val  = TW'(DEATH_FRAMES);
          event_d  = 1'b1;
        end else begin
          score_d   = score_sat;
          pellets_d = pel_left;
          event_d   = (add != '0);
          if (state_q == PLAY && hit_power) mult_d = MW'(GHOST_PTS_BASE);
          if (state_q == POWER && hit_ghost) mult_d = mult_next;
          if ((pel_hits != 2'd0) && (pel_left == '0)) begin
            state_d  = LEVEL_CLEAR;
            tmr_load = 1'b1;
            tmr_val  = TW'(CLEAR_FRAMES);
          end else if (hit_power) begin
            state_d  = POWER;
            tmr_load = 1'b1;
            tmr_val  = TW'(POWER_FRAMES);
          end else if (state_q == POWER && tmr_done) begin
            state_d = PLAY;
          end
`ifdef EXTRA_LIFE_EN
          if (!bonus_q && score_d >= SCORE_W'(EXTRA_LIFE_SCORE)) begin
            bonus_d = 1'b1;
            lives_d = (lives_q == 3'd7) ? lives_q : lives_q + 3'd1;
            event_d = 1'b1;
          end
`endif
        end
      end
      DYING: begin
        if (tmr_done) state_d = (lives_q != 3'd0) ? PLAY : GAME_OVER;
      end
      LEVEL_CLEAR: begin
        if (tmr_done) begin
          state_d   = PLAY;
          level_d   = (level_q == 4'd15) ? level_q : level_q + 4'd1;
          pellets_d = PW'(PELLET_COUNT);
        end
      end
      GAME_OVER: begin
        if (start_key) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    freeze_d = !(state_d == PLAY || state_d == POWER);
    fright_d = (state_d == POWER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      score_q   <= '0;
      lives_q   <= 3'(LIVES_INIT);
      level_q   <= 4'd1;
      pellets_q <= PW'(PELLET_COUNT);
      mult_q    <= MW'(GHOST_PTS_BASE);
      freeze_q  <= 1'b1;
      fright_q  <= 1'b0;
      event_q   <= 1'b0;
`ifdef EXTRA_LIFE_EN
      bonus_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      pellets_q <= pellets_d;
      mult_q    <= mult_d;
      freeze_q  <= freeze_d;
      fright_q  <= fright_d;
      event_q   <= event_d;
`ifdef EXTRA_LIFE_EN
      bonus_q   <= bonus_d;
`endif
    end
  end

  assign game_state       = state_q;
  assign score            = score_q;
  assign lives            = lives_q;
  assign level            = level_q;
  assign freeze_motion    = freeze_q;
  assign ghost_frightened = fright_q;
  assign event_pulse      = event_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer: vector table plus multi-frame sequences.
module tb_game_state_sequencer;

`ifdef EXTRA_LIFE_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        start_key = 1'b0;
  logic        hit_pellet = 1'b0;
  logic        hit_power = 1'b0;
  logic        hit_ghost = 1'b0;
  logic [2:0]  game_state;
  logic        freeze_motion;
  logic        ghost_frightened;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [3:0]  level;
  logic        event_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_state_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .startOfFrame     (startOfFrame),
    .start_key        (start_key),
    .hit_pellet       (hit_pellet),
    .hit_power        (hit_power),
    .hit_ghost        (hit_ghost),
    .game_state       (game_state),
    .freeze_motion    (freeze_motion),
    .ghost_frightened (ghost_frightened),
    .score            (score),
    .lives            (lives),
    .level            (level),
    .event_pulse      (event_pulse)
  );

  typedef struct {
    logic rst, st, sof, hp, hpw, hg;
    int   state, score, lives, level, frz, frt, ev;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input int sc, input int lv,
                           input int lvl, input int frz, input int frt, input int ev);
    chk({tag, " state"}, int'(game_state), st);
    chk({tag, " score"}, int'(score), sc);
    chk({tag, " lives"}, int'(lives), lv);
    chk({tag, " level"}, int'(level), lvl);
    chk({tag, " freeze"}, int'(freeze_motion), frz);
    chk({tag, " fright"}, int'(ghost_frightened), frt);
    if (ev >= 0) chk({tag, " event"}, int'(event_pulse), ev);
  endtask

  // Drive for one clock from a negedge; outputs are stable at the following negedge.
  task automatic cyc(input logic rst, input logic st, input logic sof,
                     input logic hp, input logic hpw, input logic hg);
    reset = rst; start_key = st; startOfFrame = sof;
    hit_pellet = hp; hit_power = hpw; hit_ghost = hg;
    @(negedge clk);
    reset = 1'b0; start_key = 1'b0; startOfFrame = 1'b0;
    hit_pellet = 1'b0; hit_power = 1'b0; hit_ghost = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0);
  endtask

  task automatic pellets(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    //            rst st sof hp hpw hg | state score lives lvl frz frt ev
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0,    0, 3, 1, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0,  1,    0, 3, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0,  1,   10, 3, 1, 0, 0, 1};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  1,   10, 3, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 0, 0,  1,   20, 3, 1, 0, 0, 1};
    vecs[5]  = '{0, 0, 0, 1, 0, 0,  1,   30, 3, 1, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 1, 0,  2,   80, 3, 1, 0, 1, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 1,  2,  280, 3, 1, 0, 1, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 1,  2,  680, 3, 1, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 1,  2, 1480, 3, 1, 0, 1, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1,  2, 3080, 3, 1, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 1,  2, 4680, 3, 1, 0, 1, 1};
    vecs[12] = '{0, 0, 0, 1, 0, 1,  2, 6290, 3, 1, 0, 1, 1};
    vecs[13] = '{0, 1, 0, 0, 0, 0,  2, 6290, 3, 1, 0, 1, 0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].sof, vecs[i].hp, vecs[i].hpw, vecs[i].hg);
      check_out($sformatf("vec%0d", i), vecs[i].state, vecs[i].score, vecs[i].lives,
                vecs[i].level, vecs[i].frz, vecs[i].frt, vecs[i].ev);
    end

    // Frightened timer: 180 frames from the power pellet; 59 pellets remain.
    frames(179);
    check_out("power179", 2, 6290, 3, 1, 0, 1, 0);
    frames(1);
    check_out("power180", 1, 6290, 3, 1, 0, 0, 0);

    pellets(58);
    check_out("pel58", 1, 6870, 3, 1, 0, 0, 1);
    pellets(1);
    check_out("clear1", 4, 6880, 3, 1, 1, 0, 1);
    pellets(1);
    check_out("clear_ignore", 4, 6880, 3, 1, 1, 0, 0);
    frames(89);
    check_out("clear89", 4, 6880, 3, 1, 1, 0, 0);
    frames(1);
    check_out("clear90", 1, 6880, 3, 2, 0, 0, 0);

    // Pellet counter reloaded to 64 on level 2.
    pellets(63);
    check_out("l2_pel63", 1, 7510, 3, 2, 0, 0, 1);
    pellets(1);
    check_out("l2_pel64", 4, 7520, 3, 2, 1, 0, 1);
    frames(90);
    check_out("l3_start", 1, 7520, 3, 3, 0, 0, 0);

    cyc(0, 0, 0, 1, 0, 1);
    check_out("die_pel", 3, 7520, 2, 3, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    check_out("die_ignore", 3, 7520, 2, 3, 1, 0, 0);
    frames(59);
    check_out("die59", 3, 7520, 2, 3, 1, 0, 0);
    frames(1);
    check_out("die60", 1, 7520, 2, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    frames(60);
    check_out("die2", 1, 7520, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check_out("die_last", 3, 7520, 0, 3, 1, 0, 1);
    frames(60);
    check_out("gameover", 5, 7520, 0, 3, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check_out("go_ignore", 5, 7520, 0, 3, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check_out("go_idle", 0, 7520, 0, 3, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check_out("newgame", 1, 0, 3, 1, 0, 0, 0);

    // Climb to saturation through capped ghost points.
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    check_out("sat_1450", 2, 1450, 3, 1, 0, 1, 1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 1);
    check_out("sat_65450", 2, 65450, 3 + BONUS, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    pellets(3);
    check_out("sat_65530", 2, 65530, 3 + BONUS, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check_out("sat_power", 2, 65535, 3 + BONUS, 1, 0, 1, -1);
    cyc(0, 0, 0, 0, 0, 1);
    check_out("sat_ghost", 2, 65535, 3 + BONUS, 1, 0, 1, -1);

    cyc(1, 0, 0, 1, 0, 0);
    check_out("midreset", 0, 0, 3, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
